// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter.
// Merges the single-cycle ALU result stream with a queued long-latency
// result stream into one registered write port, and tracks which
// registers still await a long-path result so decode can stall on RAW.
module reg_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_wn,
  input  logic [31:0] alu_wd,
  input  logic        lng_valid,
  input  logic [4:0]  lng_wn,
  input  logic [31:0] lng_wd,
  output logic        lng_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wn,
  input  logic [4:0]  rna,
  input  logic [4:0]  rnb,
  output logic        busy_a,
  output logic        busy_b,
  output logic        wr_en,
  output logic [4:0]  wn,
  output logic [31:0] wd
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [4:0]    fifo_wn [DEPTH];
  logic [31:0]   fifo_wd [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   busy;

  logic          push;
  logic          pop;
  logic          alu_hit;
  logic [4:0]    head_wn;
  logic [31:0]   head_wd;
  logic [31:0]   set_vec;
  logic [31:0]   clr_vec;
  logic [31:0]   busy_nxt;

  // ALU writes to r0 are discarded, so they must not steal the port from the FIFO.
  assign alu_hit   = alu_valid & (alu_wn != 5'd0);
  assign lng_ready = (count != FULL_CNT);
  assign push      = lng_valid & lng_ready;
  assign pop       = ~alu_hit & (count != '0);
  assign head_wn   = fifo_wn[rd_ptr];
  assign head_wd   = fifo_wd[rd_ptr];

  assign busy_a = (rna != 5'd0) & busy[rna];
  assign busy_b = (rnb != 5'd0) & busy[rnb];

  // Scoreboard next state: a new issue outranks a same-cycle retire of that register.
  always_comb begin
    set_vec  = iss_valid ? (32'd1 << iss_wn) : 32'd0;
    clr_vec  = pop ? (32'd1 << head_wn) : 32'd0;
    busy_nxt = ((busy & ~clr_vec) | set_vec) & ~32'd1;
  end

  // Queue storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wn[wr_ptr] <= lng_wn;
      fifo_wd[wr_ptr] <= lng_wd;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pending-write scoreboard for long-latency destinations.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Registered write port: ALU first, then queue head; wn/wd hold when idle.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_en <= 1'b0;
      wn    <= 5'd0;
      wd    <= 32'd0;
    end else if (alu_hit) begin
      wr_en <= 1'b1;
      wn    <= alu_wn;
      wd    <= alu_wd;
    end else if (pop) begin
      wr_en <= (head_wn != 5'd0);
      wn    <= head_wn;
      wd    <= head_wd;
    end else begin
      wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: a per-cycle vector table followed by
// a hand-written asynchronous reset sequence.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        Reset;
  logic        alu_valid;
  logic [4:0]  alu_wn;
  logic [31:0] alu_wd;
  logic        lng_valid;
  logic [4:0]  lng_wn;
  logic [31:0] lng_wd;
  logic        lng_ready;
  logic        iss_valid;
  logic [4:0]  iss_wn;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic        busy_a;
  logic        busy_b;
  logic        wr_en;
  logic [4:0]  wn;
  logic [31:0] wd;

  int total = 0;
  int bad   = 0;

  reg_wb_arbiter #(.DEPTH(2), .AW(1)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .alu_valid (alu_valid),
    .alu_wn    (alu_wn),
    .alu_wd    (alu_wd),
    .lng_valid (lng_valid),
    .lng_wn    (lng_wn),
    .lng_wd    (lng_wd),
    .lng_ready (lng_ready),
    .iss_valid (iss_valid),
    .iss_wn    (iss_wn),
    .rna       (rna),
    .rnb       (rnb),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .wr_en     (wr_en),
    .wn        (wn),
    .wd        (wd)
  );

  always #5 clk = ~clk;

  // One record per cycle: inputs driven in that cycle and the outputs
  // expected to be visible during that same cycle (before its closing edge).
  typedef struct {
    logic        av;
    logic [4:0]  awn;
    logic [31:0] awd;
    logic        lv;
    logic [4:0]  lwn;
    logic [31:0] lwd;
    logic        iv;
    logic [4:0]  iwn;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        e_wr;
    logic [4:0]  e_wn;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_ba;
    logic        e_bb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] awn, input logic [31:0] awd,
    input logic lv, input logic [4:0] lwn, input logic [31:0] lwd,
    input logic iv, input logic [4:0] iwn,
    input logic [4:0] ra, input logic [4:0] rb,
    input logic e_wr, input logic [4:0] e_wn, input logic [31:0] e_wd,
    input logic e_rdy, input logic e_ba, input logic e_bb);
    vec_t v;
    v.av = av; v.awn = awn; v.awd = awd;
    v.lv = lv; v.lwn = lwn; v.lwd = lwd;
    v.iv = iv; v.iwn = iwn; v.ra = ra; v.rb = rb;
    v.e_wr = e_wr; v.e_wn = e_wn; v.e_wd = e_wd;
    v.e_rdy = e_rdy; v.e_ba = e_ba; v.e_bb = e_bb;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=0x%0h expected=0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_wn = 5'd0; alu_wd = 32'd0;
    lng_valid = 1'b0; lng_wn = 5'd0; lng_wd = 32'd0;
    iss_valid = 1'b0; iss_wn = 5'd0;
    rna = 5'd0; rnb = 5'd0;
  endtask

  initial begin
    const logic [31:0] B0 = 32'hB000_0000;
    const logic [31:0] B1 = 32'hB000_0001;
    const logic [31:0] B2 = 32'hB000_0002;
    const logic [31:0] K  = 32'h1234_5678;
    const logic [31:0] DB = 32'hDEAD_BEEF;
    const logic [31:0] BD = 32'h0BAD_0BAD;

    //            av awn awd            lv lwn lwd            iv iwn  ra rb   wr wn  wd             rdy ba bb
    // single ALU write
    vecs.push_back(mk(1, 8, K,            0, 0, 0,            0, 0,   0, 0,   0, 0,  0,             1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   0, 0,   1, 8,  K,             1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   0, 0,   0, 8,  K,             1, 0, 0));
    // long write with scoreboard on r9
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 9,   9, 0,   0, 8,  K,             1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   9, 0,   0, 8,  K,             1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   9, 0,   0, 8,  K,             1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 9, DB,           0, 0,   9, 0,   0, 8,  K,             1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   9, 0,   0, 8,  K,             1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   9, 0,   1, 9,  DB,            1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   9, 0,   0, 9,  DB,            1, 0, 0));
    // ALU burst of 4 against 3 long results: fill, stall, in-order drain with wrap
    vecs.push_back(mk(1, 1, 32'hA0000001, 1, 10, B0,          0, 0,   0, 0,   0, 9,  DB,            1, 0, 0));
    vecs.push_back(mk(1, 2, 32'hA0000002, 1, 11, B1,          0, 0,   0, 0,   1, 1,  32'hA0000001,  1, 0, 0));
    vecs.push_back(mk(1, 3, 32'hA0000003, 1, 12, B2,          0, 0,   0, 0,   1, 2,  32'hA0000002,  0, 0, 0));
    vecs.push_back(mk(1, 4, 32'hA0000004, 1, 12, B2,          0, 0,   0, 0,   1, 3,  32'hA0000003,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 12, B2,          0, 0,   0, 0,   1, 4,  32'hA0000004,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 12, B2,          0, 0,   0, 0,   1, 10, B0,            1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   0, 0,   1, 11, B1,            1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   0, 0,   1, 12, B2,            1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   0, 0,   0, 12, B2,            1, 0, 0));
    // r0 handling: dropped ALU write lets the queue pop; long result to r0 pops silently
    vecs.push_back(mk(0, 0, 0,            1, 3, 32'h33333333, 0, 0,   0, 0,   0, 12, B2,            1, 0, 0));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,            0, 0,   0, 0,   0, 12, B2,            1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   0, 0,   1, 3,  32'h33333333,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 0, BD,           1, 0,   0, 0,   0, 3,  32'h33333333,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   0, 0,   0, 3,  32'h33333333,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   0, 0,   0, 0,  BD,            1, 0, 0));
    // set/clear collision on r4, then a clean clear
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 4,   0, 4,   0, 0,  BD,            1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 4, 32'h44444444, 0, 0,   0, 4,   0, 0,  BD,            1, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 4,   0, 4,   0, 0,  BD,            1, 0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 4, 32'h55555555, 0, 0,   0, 4,   1, 4,  32'h44444444,  1, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   0, 4,   0, 4,  32'h44444444,  1, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0,   4, 4,   1, 4,  32'h55555555,  1, 0, 0));

    drive_idle();
    Reset = 1'b0;
    #2;
    chk("rst_wr_en", -1, 32'(wr_en), 32'd0);
    chk("rst_wn",    -1, 32'(wn),    32'd0);
    chk("rst_wd",    -1, wd,         32'd0);
    chk("rst_ready", -1, 32'(lng_ready), 32'd1);
    #10 Reset = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      alu_valid = vecs[i].av; alu_wn = vecs[i].awn; alu_wd = vecs[i].awd;
      lng_valid = vecs[i].lv; lng_wn = vecs[i].lwn; lng_wd = vecs[i].lwd;
      iss_valid = vecs[i].iv; iss_wn = vecs[i].iwn;
      rna = vecs[i].ra; rnb = vecs[i].rb;
      #2;
      chk("wr_en",     i, 32'(wr_en),     32'(vecs[i].e_wr));
      chk("wn",        i, 32'(wn),        32'(vecs[i].e_wn));
      chk("wd",        i, wd,             vecs[i].e_wd);
      chk("lng_ready", i, 32'(lng_ready), 32'(vecs[i].e_rdy));
      chk("busy_a",    i, 32'(busy_a),    32'(vecs[i].e_ba));
      chk("busy_b",    i, 32'(busy_b),    32'(vecs[i].e_bb));
    end

    // Mid-stream reset: two entries queued behind a sustained ALU stream, r5 pending.
    @(posedge clk); #1;
    drive_idle();
    alu_valid = 1'b1; alu_wn = 5'd1; alu_wd = 32'h11;
    iss_valid = 1'b1; iss_wn = 5'd5;
    lng_valid = 1'b1; lng_wn = 5'd5; lng_wd = 32'hC5;
    rna = 5'd5;
    @(posedge clk); #1;
    iss_valid = 1'b0; iss_wn = 5'd0;
    lng_wn = 5'd6; lng_wd = 32'hC6;
    @(posedge clk); #1;
    lng_valid = 1'b0;
    #1;
    chk("pre_rst_ready",  100, 32'(lng_ready), 32'd0);
    chk("pre_rst_busy_a", 100, 32'(busy_a),    32'd1);
    chk("pre_rst_wr_en",  100, 32'(wr_en),     32'd1);
    Reset = 1'b0;
    #1;
    chk("async_rst_wr_en",  101, 32'(wr_en),     32'd0);
    chk("async_rst_ready",  101, 32'(lng_ready), 32'd1);
    chk("async_rst_busy_a", 101, 32'(busy_a),    32'd0);
    chk("async_rst_wn",     101, 32'(wn),        32'd0);
    chk("async_rst_wd",     101, wd,             32'd0);
    drive_idle();
    rna = 5'd5;
    @(posedge clk); #3;
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #3;
      chk("post_rst_wr_en",  102 + k, 32'(wr_en),     32'd0);
      chk("post_rst_busy_a", 102 + k, 32'(busy_a),    32'd0);
      chk("post_rst_ready",  102 + k, 32'(lng_ready), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Write-side companion of the 32x32 register file; sole driver of its write port (write enable, Wn, Wd).
- Merges the single-cycle ALU result stream with a long-latency result stream (loads, mul/div) through a small FIFO, giving at most one register write per cycle.
- Keeps a per-register pending scoreboard so decode can detect RAW hazards on the two read register numbers.

Parameters:
- DEPTH, 2, long-path FIFO entries (power of 2, >=2)
- AW, 1, FIFO pointer width, log2(DEPTH)

Ports:
- clk  input  1  system clock; all state updates on posedge
- Reset  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU result present this cycle, no backpressure
- alu_wn  input  5  ALU destination register
- alu_wd  input  32  ALU result
- lng_valid  input  1  long-path result offered
- lng_wn  input  5  long-path destination
- lng_wd  input  32  long-path result
- lng_ready  output  1  FIFO can accept; transfer when lng_valid & lng_ready
- iss_valid  input  1  long op issued this cycle
- iss_wn  input  5  destination of issued long op
- rna  input  5  decode read register A
- rnb  input  5  decode read register B
- busy_a  output  1  rna has a pending long write
- busy_b  output  1  rnb has a pending long write
- wr_en  output  1  register-file write enable
- wn  output  5  register-file write register
- wd  output  32  register-file write data

Behaviour:
- Reset low, asynchronous: FIFO empty (pointers and count 0); busy[31:1] = 0; wr_en = 0, wn = 0, wd = 0. Reset low mid-operation discards all queued results and pending bits.
- lng_ready = (count != DEPTH). Combinational from registered count only, with no dependence on lng_valid.
- Accept: lng_valid & lng_ready pushes {lng_wn, lng_wd} at posedge.
- Arbitration (registered, 1-cycle latency, so writes land at the register file's following negedge):
  - alu_valid & alu_wn != 0 -> wr_en=1, wn=alu_wn, wd=alu_wd. ALU always wins; the FIFO holds.
  - else FIFO non-empty -> pop head; wr_en = (head_wn != 0), wn=head_wn, wd=head_wd.
  - else wr_en=0. wn and wd hold their previous values.
- alu_valid with alu_wn = 0: the result is dropped and does not block the FIFO, which may pop that cycle.
- Simultaneous push and pop: both occur and count is unchanged. A push into an empty FIFO is not popped in the same cycle; the earliest write is 2 cycles after acceptance.
- FIFO is strictly in-order and wraps modulo DEPTH. Count is never above DEPTH or below 0.
- Scoreboard, per reg r in 1..31:
  - set when iss_valid & iss_wn == r
  - clear when a FIFO pop with head_wn == r is performed
  - simultaneous set and clear of the same r -> set wins
  - iss_wn = 0 is ignored
- busy_a = (rna != 0) & busy[rna]; busy_b likewise. Combinational read of registered state. Register 0 is never busy.
- ALU writes never touch the scoreboard.
- Sustained alu_valid starves the FIFO. lng_ready falls once count = DEPTH, and producers must hold lng_valid/lng_wn/lng_wd stable until accepted.

Test Plan:
- Reset low mid-stream with 2 queued entries and busy[5]=1 -> immediately wr_en=0, lng_ready=1, busy_a=0 for rna=5. After release, no stale write appears.
- Single ALU write: alu_valid=1, alu_wn=8, alu_wd=0x12345678 at cycle 0 -> cycle 1 wr_en=1, wn=8, wd=0x12345678. Cycle 2 wr_en=0.
- Long write with scoreboard: iss_valid, iss_wn=9 at cycle 0 -> busy_a=1 (rna=9). Push lng_wn=9, wd=0xDEADBEEF at cycle 3 -> write at cycle 5. busy_a drops after the cycle-4 pop edge.
- Contention and full: alu_valid held 4 cycles while 3 long results are offered -> lng_ready=0 after 2 accepts. The FIFO drains in order on the first free cycles after the ALU burst, and the third result is then accepted.
- Register 0: alu_wn=0 with FIFO holding wn=3 -> same-cycle pop, write to r3. A long result to r0 is accepted and popped with wr_en=0.
- Set/clear collision: busy[4]=1, pop of wn=4 in the same cycle as iss_valid, iss_wn=4 -> busy[4] remains 1.
